chunked_serial_adder: RTL
=========================

Name: chunked_serial_adder

Overview:
Parametrised multi-cycle successor to the 4-bit combinational parallel adder. It adds or subtracts two WIDTH-bit operands by processing CHUNK bits per clock through one shared CHUNK-bit adder slice, and produces sum, carry, signed-overflow and zero flags. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand source (register file or test sequencer) and a result sink, trading latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per CALC cycle; 1 <= CHUNK <= WIDTH.
NCHUNK, WIDTH/CHUNK, derived localparam: number of CALC cycles per operation.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand bundle valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
C_in  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0: S = A + B + C_in; 1: S = A - B - C_in.
out_valid  output  1  result bundle valid.
out_ready  input  1  sink accepts result.
S  output  WIDTH  result, modulo 2^WIDTH.
C_out  output  1  carry out of the MSB (for sub: 1 = no borrow).
ovf  output  1  signed two's-complement overflow.
zero  output  1  S == 0.

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1, out_valid=0, S=0, C_out=0, ovf=0, zero=0; internal shift registers, chunk counter and carry cleared. A reset mid-operation abandons it and produces no result.
- FSM states IDLE, CALC, DONE.
- IDLE: in_ready=1. On the edge where in_valid & in_ready: latch A; latch B, inverted when sub=1; initialise carry = C_in XOR sub; clear the counter; go to CALC.
- CALC: in_ready=0. Each cycle, add the low CHUNK bits of the A and B shift registers plus carry. Shift the sum chunk into the result register from the top, shift both operand registers right by CHUNK, and update carry. After NCHUNK cycles (counter = NCHUNK-1), go to DONE.
- Flags are computed on the last CALC cycle:
  - C_out = final carry.
  - ovf = carry into MSB XOR carry out of MSB, taken from the last slice.
  - zero = full result equals 0.
- Latency: out_valid rises NCHUNK cycles after the accepting edge. With CHUNK=WIDTH this is 1 cycle.
- DONE: out_valid=1. S and flags stay stable until the edge where out_ready=1; then go to IDLE and out_valid=0 on the next cycle. in_ready=0 in DONE; in_valid is ignored, and no operand is lost because in_ready was low.
- Throughput: at best one operation per NCHUNK+2 cycles. There is no overlap of acceptance with DONE.
- S and flags keep the last result after the handshake until the next result is written. They are qualified only by out_valid.
- Operand changes on A/B/C_in/sub while not accepting have no effect.
- Arithmetic wraps modulo 2^WIDTH. Sub with C_in=1 subtracts an extra 1.

Decomposition:
- Shared package adder_pkg:
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - Default WIDTH/CHUNK constants.
  - Function computing the counter width as clog2(NCHUNK) with a minimum of 1.
- One sub-module, chunk_adder (parameter CHUNK): combinational CHUNK-bit ripple adder with outputs sum, carry_out and carry_into_msb. It is instantiated once and reused each CALC cycle.

Test Plan (WIDTH=16, CHUNK=4):
1. Basic add and latency: A=0x00FF, B=0x0001, C_in=0, sub=0, out_ready=1 -> out_valid high exactly 4 cycles after accept; S=0x0100, C_out=0, ovf=0, zero=0.
2. Add boundary cases:
   - A=0xFFFF, B=0x0001 add -> S=0x0000, C_out=1, zero=1, ovf=0.
   - A=0x7FFF, B=0x0001 add -> S=0x8000, C_out=0, ovf=1.
3. Subtract cases:
   - A=0x0005, B=0x0007, C_in=0, sub=1 -> S=0xFFFE, C_out=0, ovf=0.
   - A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, C_out=1, ovf=1.
   - A=0x0005, B=0x0005, C_in=1, sub=1 -> S=0xFFFF, C_out=0.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> S and flags unchanged, in_ready=0, new operands not consumed. Raise out_ready -> out_valid drops next cycle, then in_ready=1.
5. Reset mid-operation: assert rst 2 cycles into CALC -> out_valid=0, S=0, in_ready=1 immediately (async). After release, A=0x1234, B=0x1111 add -> S=0x2345.
6. Sweep against a behavioural model: A increments by 1, B decrements by 1, C_in toggles every 4 operations, sub alternates, CHUNK in {1,4,16}, out_ready randomised -> every handshaked result matches the model for {C_out, S}, ovf and zero.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the chunked serial adder: FSM encoding,
// default geometry and the chunk-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand and result handshake bundle of the chunked serial adder.
// The slave side is the adder; the master side is the source/sink.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, A, B, C_in, sub, out_ready,
    input  in_ready, out_valid, S, C_out, ovf, zero
  );

  modport slave (
    input  in_valid, A, B, C_in, sub, out_ready,
    output in_ready, out_valid, S, C_out, ovf, zero
  );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice; also exposes the carry entering
// its top bit so the caller can form the signed-overflow flag.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic w_c;

  always_comb begin
    w_c    = i_cin;
    o_sum  = '0;
    o_cmsb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) o_cmsb = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: one shared CHUNK-bit slice is reused over
// WIDTH/CHUNK cycles, with valid/ready handshakes on operands and results.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic                  clk,
  input logic                  rst,
  chunked_serial_adder_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_s;
  logic             r_carry, r_cout, r_ovf, r_zero;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout, w_cmsb;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_last, w_in_ready, w_out_valid;

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .i_a    (r_a[CHUNK-1:0]),
    .i_b    (r_b[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // Sum chunks enter from the top so the LSB chunk ends up at the bottom.
  if (CHUNK == WIDTH) begin : g_full
    assign w_acc_nxt = w_sum;
  end else begin : g_part
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:CHUNK]};
  end

  assign w_last = (r_cnt == CW'(NCHUNK - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && bus.in_valid) begin
        // Subtraction is A + ~B + 1, with borrow-in removing that +1.
        r_a     <= bus.A;
        r_b     <= bus.sub ? ~bus.B : bus.B;
        r_carry <= bus.C_in ^ bus.sub;
        r_cnt   <= '0;
      end else if (r_state == ST_CALC) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_acc   <= w_acc_nxt;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_s    <= w_acc_nxt;
          r_cout <= w_cout;
          r_ovf  <= w_cmsb ^ w_cout;
          r_zero <= (w_acc_nxt == '0);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.S         = r_s;
  assign bus.C_out     = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule
